alu_mul_sequencer: RTL and testbench
====================================

ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 SHALL have no parameters; widths fixed (data 32, control 4, shamt 5).
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request multiply; sampled only in IDLE
- op_a  in  32  multiplicand; captured on accepted start
- op_b  in  32  multiplier; captured on accepted start
- busy  out  1  high in ADD, SHL, SHR
- done  out  1  one-cycle pulse, high only in DONE
- product  out  32  low 32 bits of op_a*op_b; registered
- alu_in1  out  32  to ALU input1
- alu_in2  out  32  to ALU input2
- alu_shamt  out  5  to ALU shamt
- alu_control  out  4  to ALU control
- alu_out  in  32  from ALU out; combinational within the same cycle
REQ-003 SHALL be the sole driver of the shared ALU operand/control inputs.

Function
REQ-004 SHALL implement FSM states IDLE, ADD, SHL, SHR, DONE.
REQ-005 IDLE: start=1 -> capture acc=0, mcand=op_a, mplier=op_b, iter=0; next state ADD. start=0 -> stay in IDLE.
REQ-006 ADD: drive alu_in1=acc, alu_in2=mcand, alu_control=4'b1000, alu_shamt=0; acc<=alu_out only if mplier[0]=1; next state SHL.
REQ-007 SHL: drive alu_in1=mcand, alu_in2=32'd1, alu_shamt=5'd1, alu_control=4'b0100; mcand<=alu_out; next state SHR.
REQ-008 SHR: drive alu_in1=mplier, alu_in2=32'd1, alu_shamt=5'd1, alu_control=4'b0101 (logical right; ALU takes shift amount from input2); mplier<=alu_out; iter<=iter+1.
REQ-009 From SHR: next state ADD if iter<31, else DONE. iter is a 5-bit counter.
REQ-010 DONE: product<=acc at entry to DONE (registered, visible while done=1); done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-011 Fixed latency: start sampled at edge E0 -> done high in the cycle after edge E0+96 (32 iterations x 3 cycles), independent of operand values.
REQ-012 IDLE and DONE: drive alu_control=4'b0111, alu_in1=0, alu_in2=0, alu_shamt=0.
REQ-013 Outputs alu_* SHALL be combinational decodes of state and internal registers only; no combinational path from start/op_a/op_b to alu_*.
REQ-014 start in ADD/SHL/SHR/DONE SHALL be ignored; no restart and no operand recapture. start in IDLE the cycle after DONE SHALL be accepted.
REQ-015 Overflow: result bits above bit 31 discarded; the ALU carry output is unused.
REQ-016 product SHALL hold its value from DONE until the next DONE; it SHALL NOT change during a computation.
REQ-017 Signed and unsigned operands give identical low-32 result; no sign handling required.

Reset
REQ-018 rst=1 SHALL asynchronously force state=IDLE, acc=0, mcand=0, mplier=0, iter=0, product=0, busy=0, done=0.
REQ-019 rst asserted mid-operation SHALL abort the operation; no done pulse; product=0 after reset.
REQ-020 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-021 op_a=3, op_b=5, start pulse -> busy high 96 cycles, then done=1 for one cycle, product=32'd15.
REQ-022 op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF -> product=32'h00000001 at done.
REQ-023 op_a=32'h00010000, op_b=32'h00010000 -> product=32'h00000000 (truncation); op_a=32'h12345678, op_b=0 -> product=0 at the same latency.
REQ-024 start=1 with op_a=7, op_b=9 held continuously -> one done every 98 cycles (IDLE, 96 busy, DONE), product=63; pulsing start with op_a=2, op_b=2 at cycle 40 of a 3x5 run -> ignored, result 15.
REQ-025 rst pulse at cycle 50 of a 6x7 run -> busy=0, done=0, product=0 immediately (asynchronous); a new start with 6x7 afterwards -> product=42.
REQ-026 Monitor every cycle: alu_control in IDLE/DONE is 4'b0111; alu_control in ADD/SHL/SHR is 4'b1000/4'b0100/4'b0101; busy and done never both high.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 32x32 -> low-32 shift-and-add multiplier that drives an
// external shared ALU. Each of the 32 iterations takes three cycles:
// ADD (conditional accumulate), SHL (multiplicand << 1) and SHR
// (multiplier >> 1). The result is registered on entry to DONE and held
// until the next DONE.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] CTL_ADD  = 4'b1000;
  localparam logic [3:0] CTL_SLL  = 4'b0100;
  localparam logic [3:0] CTL_SRL  = 4'b0101;
  localparam logic [3:0] CTL_IDLE = 4'b0111;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // ALU operand/control decode: depends only on the state and internal registers.
  always_comb begin
    alu_in1     = 32'd0;
    alu_in2     = 32'd0;
    alu_shamt   = 5'd0;
    alu_control = CTL_IDLE;
    case (state_q)
      S_ADD: begin
        alu_in1     = acc_q;
        alu_in2     = mcand_q;
        alu_shamt   = 5'd0;
        alu_control = CTL_ADD;
      end
      S_SHL: begin
        alu_in1     = mcand_q;
        alu_in2     = 32'd1;
        alu_shamt   = 5'd1;
        alu_control = CTL_SLL;
      end
      S_SHR: begin
        alu_in1     = mplier_q;
        alu_in2     = 32'd1;
        alu_shamt   = 5'd1;
        alu_control = CTL_SRL;
      end
      default: begin
        alu_in1     = 32'd0;
        alu_in2     = 32'd0;
        alu_shamt   = 5'd0;
        alu_control = CTL_IDLE;
      end
    endcase
  end

  // Next-state and datapath update; the ALU result is consumed in the same cycle.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    iter_d    = iter_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = 32'd0;
          mcand_d  = op_a;
          mplier_d = op_b;
          iter_d   = 5'd0;
          state_d  = S_ADD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ADD: begin
        if (mplier_q[0]) begin
          acc_d = alu_out;
        end else begin
          acc_d = acc_q;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = alu_out;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = alu_out;
        iter_d   = iter_q + 5'd1;
        // acc is final once the last ADD has been taken, so capture it here.
        if (iter_q < 5'd31) begin
          state_d = S_ADD;
        end else begin
          state_d   = S_DONE;
          product_d = acc_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_ADD, S_SHL, S_SHR: begin
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= 32'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      iter_q    <= 5'd0;
      product_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      iter_q    <= iter_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: models the shared ALU, runs directed and
// randomized multiplies, and checks every busy cycle against operand values
// derived arithmetically from the captured inputs.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_control;
  logic [31:0] alu_out;

  int          n_checks;
  int          n_fail;
  logic [31:0] prod_ref;

  alu_mul_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .product     (product),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_shamt   (alu_shamt),
    .alu_control (alu_control),
    .alu_out     (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU (add, shift-left by shamt, logical shift-right by in2).
  always_comb begin
    alu_out = 32'd0;
    case (alu_control)
      4'b1000: alu_out = alu_in1 + alu_in2;
      4'b0100: alu_out = alu_in1 << alu_shamt;
      4'b0101: alu_out = alu_in1 >> alu_in2[4:0];
      default: alu_out = 32'd0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accumulator after i iterations: a times the low i bits of b, modulo 2^32.
  function automatic logic [31:0] acc_after(input logic [31:0] a, input logic [31:0] b, input int i);
    logic [63:0] m;
    m = (64'd1 << i) - 64'd1;
    return a * (b & m[31:0]);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_ctl"}, {28'd0, alu_control}, 32'd7);
    check_val({tag, "_in1"}, alu_in1, 32'd0);
    check_val({tag, "_prod"}, product, prod_ref);
  endtask

  // mode: 0 quiet, 1 start held high, 2 noisy inputs while busy, 3 reset at cycle 50
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] exp_p;
    int          i;
    exp_p = a * b;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    if (mode != 1) start = 1'b0;
    for (int k = 0; k < 96; k++) begin
      i = k / 3;
      check_val("busy", {31'd0, busy}, 32'd1);
      check_val("done_busy", {31'd0, done}, 32'd0);
      check_val("prod_hold", product, prod_ref);
      case (k % 3)
        0: begin
          check_val("ctl_add", {28'd0, alu_control}, 32'd8);
          check_val("add_in1", alu_in1, acc_after(a, b, i));
          check_val("add_in2", alu_in2, a << i);
        end
        1: begin
          check_val("ctl_shl", {28'd0, alu_control}, 32'd4);
          check_val("shl_in1", alu_in1, a << i);
          check_val("shl_shamt", {27'd0, alu_shamt}, 32'd1);
        end
        default: begin
          check_val("ctl_shr", {28'd0, alu_control}, 32'd5);
          check_val("shr_in1", alu_in1, b >> i);
          check_val("shr_in2", alu_in2, 32'd1);
        end
      endcase
      if (mode == 3 && k == 50) begin
        #1 rst = 1'b1;
        #1;
        prod_ref = 32'd0;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_prod", product, 32'd0);
        check_val("rst_ctl", {28'd0, alu_control}, 32'd7);
        #1 rst = 1'b0;
        tick();
        check_idle_outputs("post_rst");
        check_val("post_rst_done", {31'd0, done}, 32'd0);
        return;
      end
      if (mode == 2) begin
        start = 1'($urandom % 2);
        op_a  = $urandom;
        op_b  = $urandom;
        if (k == 40) begin
          start = 1'b1;
          op_a  = 32'd2;
          op_b  = 32'd2;
        end
      end
      tick();
    end
    check_val("done", {31'd0, done}, 32'd1);
    check_val("done_nobusy", {31'd0, busy}, 32'd0);
    check_val("product", product, exp_p);
    check_val("done_ctl", {28'd0, alu_control}, 32'd7);
    check_val("done_in2", alu_in2, 32'd0);
    prod_ref = exp_p;
    if (mode == 2) start = 1'b0;
    tick();
    check_idle_outputs("after_done");
    check_val("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    prod_ref = 32'd0;
    rst      = 1'b1;
    start    = 1'b0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    #12;
    check_idle_outputs("reset");
    check_val("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();
    check_idle_outputs("idle");

    run_mult(32'd3, 32'd5, 0);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_mult(32'h0001_0000, 32'h0001_0000, 0);
    run_mult(32'h1234_5678, 32'd0, 0);
    run_mult(32'd7, 32'd9, 1);
    run_mult(32'd7, 32'd9, 1);
    start = 1'b0;
    run_mult(32'd3, 32'd5, 2);
    run_mult(32'd6, 32'd7, 3);
    run_mult(32'd6, 32'd7, 0);
    for (int r = 0; r < 8; r++) begin
      run_mult($urandom, $urandom, (($urandom % 2) == 0) ? 0 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Every-cycle monitor: busy and done are mutually exclusive.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("busy_done_excl", {31'd0, busy & done}, 32'd0);
    end
  end

endmodule
